usb_spi_flash_arbiter: RTL and testbench
========================================

USB_SPI_FLASH_ARBITER -- requirements
Module: usb_spi_flash_arbiter

Interface
REQ-001 Parameter CS_GAP, default 4: minimum clk_48mhz cycles spi_cs_b is held high between two grants (range 1..15).
REQ-002 Parameter WDOG_CYCLES, default 65535: count of idle cycles while granted before the grant is revoked (range 1..65535).
REQ-003 clk_48mhz  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester bus request; bit 0 = USB SPI bridge endpoint, bit 1 = secondary flash client.
REQ-006 grant  output  2  one-hot-or-zero bus grant, registered.
REQ-007 req_cs_b, req_sck, req_mosi  input  2 each  per-requester SPI drive; bit i belongs to requester i.
REQ-008 req_miso  output  2  per-requester MISO return.
REQ-009 spi_cs_b, spi_sck, spi_mosi  output  1 each  flash pins.
REQ-010 spi_miso  input  1  flash data out.
REQ-011 wdog_revoke  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-012 State machine SHALL have exactly three states: IDLE, OWNED, GAP.
REQ-013 IDLE: if any req bit set, the arbiter SHALL select a winner, register grant for that bit, enter OWNED; grant visible the cycle after req is sampled (1-cycle latency).
REQ-014 Winner selection SHALL be round-robin: a sole requester wins; when both request, the requester not served by the last grant wins.
REQ-015 OWNED: grant SHALL remain stable while req of the owner stays high; req changes of the other requester SHALL be ignored.
REQ-016 OWNED: owner deasserting req SHALL clear grant on the next edge and enter GAP.
REQ-017 GAP: a 4-bit counter SHALL count CS_GAP cycles with grant = 0; on expiry enter IDLE; requests arriving during GAP are held off, not lost (evaluated in IDLE).
REQ-018 Back-to-back: owner releasing while the other requests SHALL yield grant to the other no earlier than CS_GAP+1 cycles after grant drops.
REQ-019 Pin mux SHALL be combinational from registered grant: grant[i] set -> spi_cs_b/spi_sck/spi_mosi = req_cs_b[i]/req_sck[i]/req_mosi[i]; no grant -> spi_cs_b = 1, spi_sck = 0, spi_mosi = 0.
REQ-020 req_miso[i] SHALL equal spi_miso when grant[i] set, else 0.
REQ-021 Watchdog: 16-bit counter SHALL increment each OWNED cycle in which owner req_cs_b is high and req_sck is unchanged from the previous cycle; any other OWNED cycle clears it; cleared on entry to OWNED.
REQ-022 Watchdog reaching WDOG_CYCLES SHALL clear grant, pulse wdog_revoke for one cycle, enter GAP, and record the revoked owner as last served.
REQ-023 Watchdog SHALL NOT revoke while owner req_cs_b is low (transaction in progress), regardless of duration.
REQ-024 Owner deassertion and watchdog expiry in the same cycle: normal release wins; wdog_revoke SHALL NOT pulse.
REQ-025 A requester whose grant was revoked SHALL drop and re-raise req before it can win again.

Reset
REQ-026 Reset SHALL force IDLE, grant = 0, wdog_revoke = 0, gap and watchdog counters = 0, last-served pointer = requester 1 (requester 0 wins the first tie).
REQ-027 Reset mid-transaction SHALL drive spi_cs_b high and spi_sck/spi_mosi low in the cycle after reset is sampled; no GAP is enforced after reset.
REQ-028 Outputs SHALL not change in any cycle in which reset is held high beyond their reset values.

Verification
REQ-029 req=01 from IDLE -> grant=01 one cycle later; spi pins follow requester 0; req_miso[1]=0.
REQ-030 req=11 from reset -> grant=01; requester 0 drops req -> grant=00 for exactly CS_GAP=4 cycles with spi_cs_b=1, then IDLE cycle, then grant=10.
REQ-031 WDOG_CYCLES=8, owner holds req with req_cs_b=1, sck static -> grant drops after 8 idle cycles, wdog_revoke pulses once, GAP follows.
REQ-032 WDOG_CYCLES=8, owner holds req_cs_b=0 for 100 cycles -> no revoke; grant held throughout.
REQ-033 Reset asserted while grant=10 and spi_cs_b=0 -> next cycle grant=00, spi_cs_b=1, spi_sck=0; after release req=11 -> grant=01.
REQ-034 Requester 1 raises req during GAP -> no grant until GAP expires; granted in the first cycle after the IDLE sample.

Source files
------------

// File: rtl/usb_spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// usb_spi_flash_arbiter
//
// Shares one SPI flash between two masters: requester 0 is the USB SPI bridge
// endpoint, requester 1 a secondary flash client. A three-state FSM
// (IDLE -> OWNED -> GAP -> IDLE) hands out a registered one-hot grant with
// round-robin tie breaking, holds chip-select high for CS_GAP cycles between
// owners, and revokes a grant that sits idle (CS high, SCK frozen) for
// WDOG_CYCLES cycles.
//
// Ports:
//   clk_48mhz                       clock, rising edge
//   reset                           synchronous, active-high
//   req[1:0]                        per-requester bus request
//   grant[1:0]                      registered one-hot-or-zero grant
//   req_cs_b/req_sck/req_mosi[1:0]  per-requester SPI drive
//   req_miso[1:0]                   per-requester MISO return (0 when not granted)
//   spi_cs_b/spi_sck/spi_mosi       flash pins (idle: cs_b=1, sck=0, mosi=0)
//   spi_miso                        flash data out
//   wdog_revoke                     one-cycle pulse on watchdog revoke
// -----------------------------------------------------------------------------
module usb_spi_flash_arbiter #(
    parameter int CS_GAP      = 4,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic [1:0] req_cs_b,
    input  logic [1:0] req_sck,
    input  logic [1:0] req_mosi,
    output logic [1:0] req_miso,
    output logic       spi_cs_b,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       wdog_revoke
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;          // index of the last served requester
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        revoke_q, revoke_d;
    logic [1:0]  blocked_q, blocked_d;    // revoked, waiting for req to drop
    logic [1:0]  sck_prev_q, sck_prev_d;

    logic        owner;
    logic        winner;
    logic [1:0]  eligible;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        wdog_cnt_d = wdog_cnt_q;
        revoke_d   = 1'b0;
        sck_prev_d = req_sck;
        // A revoked requester is re-armed as soon as it lets go of req.
        blocked_d  = blocked_q & req;
        winner     = 1'b0;
        owner      = grant_q[1];
        eligible   = req & ~blocked_q;

        case (state_q)
            IDLE: begin
                if (eligible != 2'b00) begin
                    // Tie goes to whoever was not served last.
                    winner     = (eligible == 2'b11) ? ~last_q : eligible[1];
                    grant_d    = winner ? 2'b10 : 2'b01;
                    last_d     = winner;
                    wdog_cnt_d = '0;
                    state_d    = OWNED;
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    // Normal release takes priority over a coincident watchdog expiry.
                    grant_d    = 2'b00;
                    gap_cnt_d  = '0;
                    wdog_cnt_d = '0;
                    state_d    = GAP;
                end else if (req_cs_b[owner] && (req_sck[owner] == sck_prev_q[owner])) begin
                    if ((wdog_cnt_q + 16'd1) == 16'(WDOG_CYCLES)) begin
                        grant_d          = 2'b00;
                        revoke_d         = 1'b1;
                        blocked_d[owner] = 1'b1;
                        gap_cnt_d        = '0;
                        wdog_cnt_d       = '0;
                        state_d          = GAP;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + 16'd1;
                    end
                end else begin
                    wdog_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'(CS_GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            gap_cnt_q  <= '0;
            wdog_cnt_q <= '0;
            revoke_q   <= 1'b0;
            blocked_q  <= 2'b00;
            sck_prev_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            wdog_cnt_q <= wdog_cnt_d;
            revoke_q   <= revoke_d;
            blocked_q  <= blocked_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign grant       = grant_q;
    assign wdog_revoke = revoke_q;

    // Pin mux straight off the registered grant; parked pins keep the flash deselected.
    assign spi_cs_b = grant_q[0] ? req_cs_b[0] : (grant_q[1] ? req_cs_b[1] : 1'b1);
    assign spi_sck  = grant_q[0] ? req_sck[0]  : (grant_q[1] ? req_sck[1]  : 1'b0);
    assign spi_mosi = grant_q[0] ? req_mosi[0] : (grant_q[1] ? req_mosi[1] : 1'b0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_miso
            assign req_miso[gi] = grant_q[gi] & spi_miso;
        end
    endgenerate

endmodule

// File: tb/tb_usb_spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_spi_flash_arbiter
//
// Directed bench for usb_spi_flash_arbiter (CS_GAP=4, WDOG_CYCLES=8): a table
// of per-cycle input/expected-output records followed by hand-written
// sequences for back-to-back handover, reset mid-transaction, watchdog revoke,
// long transactions and release/expiry collision.
// -----------------------------------------------------------------------------
module tb_usb_spi_flash_arbiter;

    logic       clk_48mhz = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] req_cs_b, req_sck, req_mosi;
    logic [1:0] req_miso;
    logic       spi_cs_b, spi_sck, spi_mosi, spi_miso;
    logic       wdog_revoke;

    int n_tests = 0;
    int n_fail  = 0;

    usb_spi_flash_arbiter #(.CS_GAP(4), .WDOG_CYCLES(8)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .req_cs_b    (req_cs_b),
        .req_sck     (req_sck),
        .req_mosi    (req_mosi),
        .req_miso    (req_miso),
        .spi_cs_b    (spi_cs_b),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .wdog_revoke (wdog_revoke)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    typedef struct {
        logic [1:0] req, cs_b, sck, mosi;
        logic       miso;
        logic [1:0] e_grant;
        logic       e_cs_b, e_sck, e_mosi;
        logic [1:0] e_miso;
        logic       e_rev;
    } vec_t;

    vec_t vecs [0:18];

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] c, input logic [1:0] s,
                                input logic [1:0] m, input logic mi, input logic [1:0] eg,
                                input logic ec, input logic es, input logic em,
                                input logic [1:0] emi, input logic er);
        vec_t v;
        v.req = r; v.cs_b = c; v.sck = s; v.mosi = m; v.miso = mi;
        v.e_grant = eg; v.e_cs_b = ec; v.e_sck = es; v.e_mosi = em;
        v.e_miso = emi; v.e_rev = er;
        return v;
    endfunction

    // {grant, spi_cs_b, spi_sck, spi_mosi, req_miso, wdog_revoke}
    function automatic logic [8:0] outs();
        return {grant, spi_cs_b, spi_sck, spi_mosi, req_miso, wdog_revoke};
    endfunction

    task automatic step();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic set_in(input logic [1:0] r, input logic [1:0] c, input logic [1:0] s,
                          input logic [1:0] m, input logic mi);
        req = r; req_cs_b = c; req_sck = s; req_mosi = m; spi_miso = mi;
    endtask

    // Hold reset for three cycles, checking outputs stay parked, then release.
    task automatic do_reset();
        reset = 1'b1;
        set_in(2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outs", 32'(outs()), 32'({2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}));
        end
        reset = 1'b0;
    endtask

    initial begin
        // in: req cs_b sck mosi miso | exp: grant cs_b sck mosi req_miso revoke
        vecs[0]  = mk(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        vecs[1]  = mk(2'b01, 2'b10, 2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        vecs[2]  = mk(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        vecs[3]  = mk(2'b11, 2'b00, 2'b10, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        vecs[4]  = mk(2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 5; i <= 8; i++)
            vecs[i] = mk(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        vecs[9]  = mk(2'b10, 2'b01, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        vecs[10] = mk(2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        vecs[11] = mk(2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 12; i <= 15; i++)
            vecs[i] = mk(2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        vecs[16] = mk(2'b01, 2'b10, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
        vecs[17] = mk(2'b11, 2'b10, 2'b00, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        vecs[18] = mk(2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int i = 0; i <= 18; i++) begin
            set_in(vecs[i].req, vecs[i].cs_b, vecs[i].sck, vecs[i].mosi, vecs[i].miso);
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].e_grant, vecs[i].e_cs_b, vecs[i].e_sck, vecs[i].e_mosi,
                     vecs[i].e_miso, vecs[i].e_rev}));
        end

        // ---------------- tie after reset, back-to-back handover ----------------
        do_reset();
        set_in(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        step();
        chk("tie_grant", 32'(grant), 32'(2'b01));
        req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("handover_gap%0d", i), 32'({grant, spi_cs_b}), 32'({2'b00, 1'b1}));
        end
        step();
        chk("handover_grant", 32'(grant), 32'(2'b10));

        // ---------------- reset mid-transaction ----------------
        set_in(2'b10, 2'b01, 2'b10, 2'b10, 1'b0);
        step();
        chk("busy_pins", 32'({grant, spi_cs_b, spi_sck, spi_mosi}), 32'({2'b10, 1'b0, 1'b1, 1'b1}));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midreset_pins", 32'(outs()), 32'({2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}));
        end
        reset = 1'b0;
        set_in(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        step();
        chk("postreset_grant", 32'(grant), 32'(2'b01));

        // ---------------- watchdog revoke + re-raise rule ----------------
        do_reset();
        set_in(2'b01, 2'b11, 2'b00, 2'b00, 1'b0);
        step();
        chk("wdog_grant", 32'({grant, wdog_revoke}), 32'({2'b01, 1'b0}));
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("wdog_hold%0d", i), 32'({grant, wdog_revoke}), 32'({2'b01, 1'b0}));
        end
        step();
        chk("wdog_revoke", 32'({grant, wdog_revoke}), 32'({2'b00, 1'b1}));
        step();
        chk("wdog_pulse_end", 32'({grant, wdog_revoke}), 32'({2'b00, 1'b0}));
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("wdog_blocked%0d", i), 32'(grant), 32'(2'b00));
        end
        req = 2'b00;
        step();
        req = 2'b01;
        step();
        chk("wdog_rearm", 32'(grant), 32'(2'b01));

        // ---------------- long transaction, then toggling SCK ----------------
        do_reset();
        set_in(2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        step();
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("long_cs%0d", i), 32'({grant, wdog_revoke}), 32'({2'b01, 1'b0}));
        end
        req_cs_b = 2'b11;
        for (int i = 0; i < 20; i++) begin
            req_sck[0] = ~req_sck[0];
            step();
            chk($sformatf("sck_toggle%0d", i), 32'({grant, wdog_revoke}), 32'({2'b01, 1'b0}));
        end

        // ---------------- release coinciding with watchdog expiry ----------------
        do_reset();
        set_in(2'b01, 2'b11, 2'b00, 2'b00, 1'b0);
        step();
        chk("collide_grant", 32'(grant), 32'(2'b01));
        for (int i = 0; i < 7; i++) step();
        req = 2'b00;
        step();
        chk("collide_release", 32'({grant, wdog_revoke}), 32'({2'b00, 1'b0}));
        step();
        chk("collide_no_pulse", 32'(wdog_revoke), 32'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
